// File: rtl/alu_pkg.sv
// Shared opcodes, flag positions and checker FSM states for the lab ALU
// and its response checker.
package alu_pkg;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_INC  = 3'b101,
    OP_PASS = 3'b110,
    OP_RSV  = 3'b111
  } alu_op_t;

  localparam int ONZ_O = 2;
  localparam int ONZ_N = 1;
  localparam int ONZ_Z = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } chk_state_t;

endpackage

// File: rtl/alu_ref_model.sv
// Combinational golden ALU: expected result and O/N/Z flags for one vector.
module alu_ref_model
  import alu_pkg::*;
#(
  parameter int width = 8
) (
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic [2:0]       op,
  output logic [width-1:0] y_exp,
  output logic [2:0]       onz_exp,
  output logic             illegal
);

  localparam int MSB = width - 1;

  logic ovf;

  always_comb begin
    y_exp   = '0;
    ovf     = 1'b0;
    illegal = 1'b0;
    onz_exp = '0;
    case (alu_op_t'(op))
      OP_ADD: begin
        y_exp = A + B;
        ovf   = (A[MSB] == B[MSB]) && (y_exp[MSB] != A[MSB]);
      end
      OP_SUB: begin
        y_exp = A - B;
        ovf   = (A[MSB] != B[MSB]) && (y_exp[MSB] != A[MSB]);
      end
      OP_AND:  y_exp = A & B;
      OP_OR:   y_exp = A | B;
      OP_XOR:  y_exp = A ^ B;
      OP_INC: begin
        y_exp = A + width'(1);
        ovf   = !A[MSB] && y_exp[MSB];
      end
      OP_PASS: y_exp = A;
      default: illegal = 1'b1;
    endcase
    onz_exp[ONZ_O] = ovf;
    onz_exp[ONZ_N] = y_exp[MSB];
    onz_exp[ONZ_Z] = (y_exp == '0);
  end

endmodule

// File: rtl/alu_checker.sv
// Two-stage ALU response checker: registers each sample, compares it against
// the reference model one cycle later and keeps per-run pass/fail statistics.
module alu_checker
  import alu_pkg::*;
#(
  parameter  int width     = 8,
  parameter  int n_vectors = 14,
  localparam int CW        = $clog2(n_vectors + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             valid,
  input  logic [width-1:0] A,
  input  logic [width-1:0] B,
  input  logic [2:0]       op,
  input  logic [width-1:0] Y,
  input  logic [2:0]       ONZ,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CW-1:0]    vec_cnt,
  output logic [CW-1:0]    fail_cnt,
  output logic [CW-1:0]    first_fail_idx,
  output logic [2:0]       first_fail_op,
  output logic             mismatch
);

  chk_state_t       state_q, state_d;
  logic             busy_q, busy_d, done_q, done_d, pass_q, pass_d;
  logic             mis_q, mis_d, smp_vld_q, smp_vld_d;
  logic [CW-1:0]    vec_q, vec_d, fail_q, fail_d, ff_idx_q, ff_idx_d;
  logic [2:0]       ff_op_q, ff_op_d;
  logic [width-1:0] a_q, a_d, b_q, b_d, y_q, y_d;
  logic [2:0]       op_q, op_d, onz_q, onz_d;

  logic [width-1:0] y_exp;
  logic [2:0]       onz_exp;
  logic             illegal, smp_fail, accept;
  logic [CW:0]      occupancy;
  logic [CW-1:0]    vec_nxt, fail_nxt;

  alu_ref_model #(.width(width)) u_ref (
    .A(a_q), .B(b_q), .op(op_q),
    .y_exp(y_exp), .onz_exp(onz_exp), .illegal(illegal)
  );

  assign smp_fail  = illegal || (y_q != y_exp) || (onz_q != onz_exp);
  // The sample completing this cycle still occupies a slot toward n_vectors.
  assign occupancy = {1'b0, vec_q} + {{CW{1'b0}}, smp_vld_q};
  assign accept    = (state_q == ST_RUN) && valid && !start
                     && (occupancy < (CW+1)'(n_vectors));
  assign vec_nxt   = vec_q + CW'(1);
  assign fail_nxt  = fail_q + CW'(smp_fail);

  always_comb begin
    state_d   = state_q;
    busy_d    = busy_q;
    done_d    = done_q;
    pass_d    = pass_q;
    vec_d     = vec_q;
    fail_d    = fail_q;
    ff_idx_d  = ff_idx_q;
    ff_op_d   = ff_op_q;
    mis_d     = 1'b0;
    smp_vld_d = 1'b0;
    a_d = a_q; b_d = b_q; op_d = op_q; y_d = y_q; onz_d = onz_q;
    if (start) begin
      state_d  = ST_RUN;
      busy_d   = 1'b1;
      done_d   = 1'b0;
      pass_d   = 1'b0;
      vec_d    = '0;
      fail_d   = '0;
      ff_idx_d = '0;
      ff_op_d  = '0;
    end else begin
      if (accept) begin
        smp_vld_d = 1'b1;
        a_d = A; b_d = B; op_d = op; y_d = Y; onz_d = ONZ;
      end
      if (smp_vld_q && state_q == ST_RUN) begin
        vec_d  = vec_nxt;
        fail_d = fail_nxt;
        mis_d  = smp_fail;
        if (smp_fail && fail_q == '0) begin
          ff_idx_d = vec_q;
          ff_op_d  = op_q;
        end
        if (vec_nxt == CW'(n_vectors)) begin
          state_d = ST_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          pass_d  = (fail_nxt == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      vec_q     <= '0;
      fail_q    <= '0;
      ff_idx_q  <= '0;
      ff_op_q   <= '0;
      mis_q     <= 1'b0;
      smp_vld_q <= 1'b0;
      a_q <= '0; b_q <= '0; op_q <= '0; y_q <= '0; onz_q <= '0;
    end else begin
      state_q   <= state_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      vec_q     <= vec_d;
      fail_q    <= fail_d;
      ff_idx_q  <= ff_idx_d;
      ff_op_q   <= ff_op_d;
      mis_q     <= mis_d;
      smp_vld_q <= smp_vld_d;
      a_q <= a_d; b_q <= b_d; op_q <= op_d; y_q <= y_d; onz_q <= onz_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign vec_cnt        = vec_q;
  assign fail_cnt       = fail_q;
  assign first_fail_idx = ff_idx_q;
  assign first_fail_op  = ff_op_q;
  assign mismatch       = mis_q;

endmodule

// File: tb/tb_alu_checker.sv
// Directed bench for alu_checker: queue-based run model checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_alu_checker;
  localparam int W  = 8;
  localparam int N  = 4;
  localparam int CW = $clog2(N + 1);

  logic clk, rst_n, start, valid;
  logic [W-1:0] A, B, Y;
  logic [2:0] op, ONZ;
  logic busy, done, pass, mismatch;
  logic [CW-1:0] vec_cnt, fail_cnt, first_fail_idx;
  logic [2:0] first_fail_op;

  int n_chk = 0, n_fail = 0;

  alu_checker #(.width(W), .n_vectors(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .valid(valid),
    .A(A), .B(B), .op(op), .Y(Y), .ONZ(ONZ),
    .busy(busy), .done(done), .pass(pass), .vec_cnt(vec_cnt),
    .fail_cnt(fail_cnt), .first_fail_idx(first_fail_idx),
    .first_fail_op(first_fail_op), .mismatch(mismatch)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
    end
  endtask

  // Golden ALU from signed integer arithmetic: returns {illegal, Y, ONZ}.
  function automatic logic [11:0] golden(input logic [2:0] o, input logic [7:0] a, b);
    int sa, sb, s;
    logic [7:0] y;
    logic ov;
    sa = int'($signed(a)); sb = int'($signed(b));
    s = 0; ov = 1'b0; y = 8'h00;
    case (o)
      3'd0: s = sa + sb;
      3'd1: s = sa - sb;
      3'd5: s = sa + 1;
      default: s = 0;
    endcase
    case (o)
      3'd0, 3'd1, 3'd5: begin y = 8'(s); ov = (s > 127) || (s < -128); end
      3'd2: y = a & b;
      3'd3: y = a | b;
      3'd4: y = a ^ b;
      3'd6: y = a;
      default: y = 8'h00;
    endcase
    return {(o == 3'd7), y, ov, y[7], (y == 8'h00)};
  endfunction

  // Run model: counts and first-fail from a queue of in-flight verdicts.
  typedef struct { int idx_op; bit bad; } verdict_t;
  verdict_t inflight[$];
  bit m_run, m_busy, m_done, m_pass, m_mis;
  int m_vec, m_fail, m_ffi, m_ffo;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inflight.delete();
      m_run = 0; m_busy = 0; m_done = 0; m_pass = 0; m_mis = 0;
      m_vec = 0; m_fail = 0; m_ffi = 0; m_ffo = 0;
    end else begin
      bit acc;
      logic [11:0] g;
      acc = m_run && valid && (m_vec + inflight.size() < N);
      m_mis = 0;
      if (start) begin
        inflight.delete();
        m_run = 1; m_busy = 1; m_done = 0; m_pass = 0;
        m_vec = 0; m_fail = 0; m_ffi = 0; m_ffo = 0;
      end else begin
        if (inflight.size() > 0) begin
          verdict_t v;
          v = inflight.pop_front();
          if (v.bad) begin
            if (m_fail == 0) begin m_ffi = m_vec; m_ffo = v.idx_op; end
            m_fail++;
            m_mis = 1;
          end
          m_vec++;
          if (m_vec == N) begin m_run = 0; m_busy = 0; m_done = 1; m_pass = (m_fail == 0); end
        end
        if (acc) begin
          verdict_t v;
          g = golden(op, A, B);
          v.idx_op = int'(op);
          v.bad = g[11] || (g[10:3] != Y) || (g[2:0] != ONZ);
          inflight.push_back(v);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("busy", int'(busy), int'(m_busy));
    chk("done", int'(done), int'(m_done));
    chk("pass", int'(pass), int'(m_pass));
    chk("vec_cnt", int'(vec_cnt), m_vec);
    chk("fail_cnt", int'(fail_cnt), m_fail);
    chk("first_fail_idx", int'(first_fail_idx), m_ffi);
    chk("first_fail_op", int'(first_fail_op), m_ffo);
    chk("mismatch", int'(mismatch), int'(m_mis));
  end

  task automatic drive(input logic [2:0] o, input logic [7:0] a, b, y, input logic [2:0] f);
    valid = 1'b1; op = o; A = a; B = b; Y = y; ONZ = f;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    valid = 1'b0;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_start();
    valid = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // The four test-plan vectors; vector bad_idx reports ONZ=000.
  task automatic std_run(input int bad_idx);
    drive(3'd0, 8'h7F, 8'h01, 8'h80, (bad_idx == 0) ? 3'b000 : 3'b110);
    drive(3'd1, 8'h00, 8'h01, 8'hFF, (bad_idx == 1) ? 3'b000 : 3'b010);
    drive(3'd2, 8'hF0, 8'h0F, 8'h00, (bad_idx == 2) ? 3'b000 : 3'b001);
    drive(3'd6, 8'h5A, 8'h00, 8'h5A, 3'b000);
  endtask

  task automatic all_zero(input string tag);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_pass"}, int'(pass), 0);
    chk({tag, "_vec"}, int'(vec_cnt), 0);
    chk({tag, "_fail"}, int'(fail_cnt), 0);
    chk({tag, "_ffi"}, int'(first_fail_idx), 0);
    chk({tag, "_ffo"}, int'(first_fail_op), 0);
    chk({tag, "_mis"}, int'(mismatch), 0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; valid = 1'b0;
    A = '0; B = '0; Y = '0; op = '0; ONZ = '0;

    chk("gold_add", int'(golden(3'd0, 8'h7F, 8'h01)), 12'h406);
    chk("gold_sub", int'(golden(3'd1, 8'h00, 8'h01)), 12'h7FA);
    chk("gold_and", int'(golden(3'd2, 8'hF0, 8'h0F)), 12'h001);
    chk("gold_inc", int'(golden(3'd5, 8'h7F, 8'h00)), 12'h406);
    chk("gold_rsv", int'(golden(3'd7, 8'h00, 8'h00)) >> 11, 1);

    repeat (2) @(negedge clk);
    all_zero("reset");
    rst_n = 1'b1;
    idle(1);

    // known-good run
    pulse_start();
    chk("busy_rise", int'(busy), 1);
    std_run(-1);
    chk("good_done_early", int'(done), 0);
    chk("good_vec_early", int'(vec_cnt), 3);
    idle(1);
    chk("good_done", int'(done), 1);
    chk("good_pass", int'(pass), 1);
    chk("good_fail_cnt", int'(fail_cnt), 0);
    chk("good_busy", int'(busy), 0);
    idle(2);

    // AND vector reports bad flags
    pulse_start();
    std_run(2);
    chk("fault_mis_pulse", int'(mismatch), 1);
    idle(1);
    chk("fault_mis_clear", int'(mismatch), 0);
    chk("fault_fail_cnt", int'(fail_cnt), 1);
    chk("fault_ffi", int'(first_fail_idx), 2);
    chk("fault_ffo", int'(first_fail_op), 2);
    chk("fault_pass", int'(pass), 0);
    chk("fault_done", int'(done), 1);
    idle(2);

    // reserved opcode with otherwise plausible result
    pulse_start();
    drive(3'd7, 8'h00, 8'h00, 8'h00, 3'b001);
    drive(3'd4, 8'hAA, 8'h0F, 8'hA5, 3'b010);
    drive(3'd3, 8'h00, 8'h00, 8'h00, 3'b001);
    drive(3'd5, 8'hFF, 8'h00, 8'h00, 3'b001);
    idle(1);
    chk("rsv_fail_cnt", int'(fail_cnt), 1);
    chk("rsv_ffi", int'(first_fail_idx), 0);
    chk("rsv_ffo", int'(first_fail_op), 7);
    chk("rsv_pass", int'(pass), 0);
    idle(2);

    // gapped valid, two extra samples after the run ends
    pulse_start();
    for (int i = 0; i < 6; i++) begin
      drive(3'd5, 8'h7F, 8'h00, 8'h80, 3'b110);
      idle(2);
      chk("gap_vec", int'(vec_cnt), (i + 1 > N) ? N : i + 1);
    end
    chk("gap_done", int'(done), 1);
    chk("gap_pass", int'(pass), 1);

    // back-to-back with one extra sample while still running
    pulse_start();
    for (int i = 0; i < 5; i++) drive(3'd0, 8'h80, 8'h80, 8'h00, 3'b101);
    idle(2);
    chk("drop_vec", int'(vec_cnt), 4);
    chk("drop_pass", int'(pass), 1);

    // restart with a failing sample in flight
    pulse_start();
    drive(3'd6, 8'h11, 8'h00, 8'h11, 3'b000);
    drive(3'd2, 8'hF0, 8'h0F, 8'h00, 3'b000);
    pulse_start();
    chk("restart_vec", int'(vec_cnt), 0);
    chk("restart_mis", int'(mismatch), 0);
    idle(1);
    chk("restart_fail", int'(fail_cnt), 0);
    std_run(-1);
    idle(1);
    chk("restart_done", int'(done), 1);
    chk("restart_pass", int'(pass), 1);
    chk("restart_vec4", int'(vec_cnt), 4);

    // async reset with a failing sample in flight
    pulse_start();
    drive(3'd6, 8'h11, 8'h00, 8'h11, 3'b000);
    valid = 1'b1; op = 3'd2; A = 8'hF0; B = 8'h0F; Y = 8'h00; ONZ = 3'b000;
    @(posedge clk);
    #2;
    chk("pre_rst_busy", int'(busy), 1);
    rst_n = 1'b0;
    #1;
    all_zero("async_rst");
    @(negedge clk);
    valid = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("post_rst_mis", int'(mismatch), 0);
    end
    drive(3'd6, 8'h22, 8'h00, 8'h22, 3'b000);
    idle(2);
    chk("idle_ignores_vec", int'(vec_cnt), 0);
    chk("idle_busy", int'(busy), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
